// File: rtl/wbank_sched.sv
// Lockstep read-address sequencer for the 16-bank weight memory. Markers travel with the
// read latency. Optional feature: define WBANK_SCHED_ABORT_EN to add the `abort` input.
module wbank_sched #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned NPASS  = 4,
    parameter int unsigned RD_LAT = 1,
    localparam int unsigned PASS_W = (NPASS > 1) ? $clog2(NPASS) : 1
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              start,
    input  logic              stall,
`ifdef WBANK_SCHED_ABORT_EN
    input  logic              abort,
`endif
    output logic [ADDR_W-1:0] raddr,
    output logic              rd_valid,
    output logic              acc_clr,
    output logic              rd_last,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              finish
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(DEPTH - 1);
    localparam logic [PASS_W-1:0] LastPass  = PASS_W'(NPASS - 1);
    localparam logic [1:0]        LastDrain = 2'(RD_LAT - 1);

    typedef struct packed {
        logic              vld;
        logic              first;
        logic              last;
        logic [PASS_W-1:0] pass;
    } rd_tag_t;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [1:0]        drain_q, drain_d;
    logic              issue;
    logic              abort_hit;
    rd_tag_t           issue_tag;
    rd_tag_t           pipe_q [RD_LAT];

`ifdef WBANK_SCHED_ABORT_EN
    assign abort_hit = abort && ((state_q == StRun) || (state_q == StDrain));
`else
    assign abort_hit = 1'b0;
`endif

    assign issue = (state_q == StRun) && !stall;

    always_comb begin
        issue_tag.vld   = issue;
        issue_tag.first = issue && (addr_q == '0);
        issue_tag.last  = issue && (addr_q == LastAddr);
        issue_tag.pass  = issue ? pass_q : '0;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = '0;
                    pass_d  = '0;
                end
            end
            StRun: begin
                if (!stall) begin
                    if (addr_q != LastAddr) begin
                        addr_d = addr_q + 1'b1;
                    end else if (pass_q != LastPass) begin
                        addr_d = '0;
                        pass_d = pass_q + 1'b1;
                    end else begin
                        state_d = StDrain;
                        drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (drain_q == LastDrain) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_hit) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            pass_q  <= '0;
            drain_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
            drain_q <= drain_d;
            // Abort drops everything in flight, including a read issued this cycle.
            if (abort_hit) begin
                for (int i = 0; i < int'(RD_LAT); i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= issue_tag;
                for (int i = 1; i < int'(RD_LAT); i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    always_comb begin
        raddr    = addr_q;
        rd_valid = pipe_q[RD_LAT-1].vld;
        acc_clr  = pipe_q[RD_LAT-1].first;
        rd_last  = pipe_q[RD_LAT-1].last;
        pass_idx = pipe_q[RD_LAT-1].pass;
        busy     = (state_q == StRun) || (state_q == StDrain);
        finish   = (state_q == StDone);
    end

endmodule

// File: tb/tb_wbank_sched.sv
// Directed bench for wbank_sched: instance A (16x4, latency 1) and B (16x1, latency 3).
// Expected timelines come from closed-form cycle arithmetic on the start cycle.
module tb_wbank_sched;

    localparam int Big = 1 << 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       xrst;
    logic       start_a, stall_a, start_b, stall_b;
    logic [3:0] raddr_a, raddr_b;
    logic       rd_valid_a, acc_clr_a, rd_last_a, busy_a, finish_a;
    logic       rd_valid_b, acc_clr_b, rd_last_b, busy_b, finish_b;
    logic [1:0] pass_idx_a;
    logic [0:0] pass_idx_b;
`ifdef WBANK_SCHED_ABORT_EN
    logic       abort_a, abort_b;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    wbank_sched #(.ADDR_W(4), .DEPTH(16), .NPASS(4), .RD_LAT(1)) u_dut_a (
        .clk      (clk),
        .xrst     (xrst),
        .start    (start_a),
        .stall    (stall_a),
`ifdef WBANK_SCHED_ABORT_EN
        .abort    (abort_a),
`endif
        .raddr    (raddr_a),
        .rd_valid (rd_valid_a),
        .acc_clr  (acc_clr_a),
        .rd_last  (rd_last_a),
        .pass_idx (pass_idx_a),
        .busy     (busy_a),
        .finish   (finish_a)
    );

    wbank_sched #(.ADDR_W(4), .DEPTH(16), .NPASS(1), .RD_LAT(3)) u_dut_b (
        .clk      (clk),
        .xrst     (xrst),
        .start    (start_b),
        .stall    (stall_b),
`ifdef WBANK_SCHED_ABORT_EN
        .abort    (abort_b),
`endif
        .raddr    (raddr_b),
        .rd_valid (rd_valid_b),
        .acc_clr  (acc_clr_b),
        .rd_last  (rd_last_b),
        .pass_idx (pass_idx_b),
        .busy     (busy_b),
        .finish   (finish_b)
    );

    typedef struct {
        int valid;
        int first;
        int last;
        int pidx;
        int busy;
        int finish;
        int raddr;
        int raddr_chk;
    } exp_t;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Read k is issued at t0+1+k, shifted by s if it falls at or after the stalled read k0.
    function automatic exp_t model(input int c, input int t0, input int k0, input int s,
                                   input int d, input int n, input int l);
        exp_t e;
        int   rel, k, fin, ri, ki;
        e   = '{default: 0};
        fin = t0 + d * n + l + 1 + s;
        rel = c - t0 - 1 - l;
        k   = -1;
        if (rel >= 0) begin
            if (rel < k0) k = rel;
            else if (rel >= k0 + s) k = rel - s;
        end
        if (k >= 0 && k < d * n) begin
            e.valid = 1;
            e.first = (k % d == 0) ? 1 : 0;
            e.last  = (k % d == d - 1) ? 1 : 0;
            e.pidx  = k / d;
        end
        e.finish = (c == fin) ? 1 : 0;
        e.busy   = (c > t0 && c < fin) ? 1 : 0;
        if (e.busy != 0) begin
            ri = c - t0 - 1;
            if (ri < k0) ki = ri;
            else if (ri < k0 + s) ki = k0;
            else ki = ri - s;
            e.raddr     = (ki >= d * n) ? d - 1 : ki % d;
            e.raddr_chk = 1;
        end else if (c >= fin) begin
            e.raddr     = d - 1;
            e.raddr_chk = 1;
        end
        return e;
    endfunction

    task automatic check_zero_a(input string tag);
        check_eq({tag, ".rd_valid"}, int'(rd_valid_a), 0);
        check_eq({tag, ".acc_clr"}, int'(acc_clr_a), 0);
        check_eq({tag, ".rd_last"}, int'(rd_last_a), 0);
        check_eq({tag, ".pass_idx"}, int'(pass_idx_a), 0);
        check_eq({tag, ".busy"}, int'(busy_a), 0);
        check_eq({tag, ".finish"}, int'(finish_a), 0);
        check_eq({tag, ".raddr"}, int'(raddr_a), 0);
    endtask

    // Checks every cycle up to c_end-1 and drives start/stall; pa/pb are extra start pulses,
    // sd holds stall high through DRAIN and DONE.
    task automatic run_window(input int which, input int t0, input int k0, input int s,
                              input int c_end, input int pa, input int pb, input bit sd);
        exp_t e;
        int   d, n, l, fin;
        logic st, stl;
        d   = 16;
        n   = (which == 0) ? 4 : 1;
        l   = (which == 0) ? 1 : 3;
        fin = t0 + d * n + l + 1 + s;
        while (cyc < c_end) begin
            e = model(cyc, t0, k0, s, d, n, l);
            if (which == 0) begin
                check_eq("a.rd_valid", int'(rd_valid_a), e.valid);
                check_eq("a.acc_clr", int'(acc_clr_a), e.first);
                check_eq("a.rd_last", int'(rd_last_a), e.last);
                check_eq("a.pass_idx", int'(pass_idx_a), e.pidx);
                check_eq("a.busy", int'(busy_a), e.busy);
                check_eq("a.finish", int'(finish_a), e.finish);
                if (e.raddr_chk != 0) check_eq("a.raddr", int'(raddr_a), e.raddr);
            end else begin
                check_eq("b.rd_valid", int'(rd_valid_b), e.valid);
                check_eq("b.acc_clr", int'(acc_clr_b), e.first);
                check_eq("b.rd_last", int'(rd_last_b), e.last);
                check_eq("b.pass_idx", int'(pass_idx_b), e.pidx);
                check_eq("b.busy", int'(busy_b), e.busy);
                check_eq("b.finish", int'(finish_b), e.finish);
                if (e.raddr_chk != 0) check_eq("b.raddr", int'(raddr_b), e.raddr);
            end
            st  = (cyc == t0 || cyc == pa || cyc == pb);
            stl = (s > 0 && cyc >= t0 + 1 + k0 && cyc < t0 + 1 + k0 + s) ||
                  (sd && cyc > t0 + d * n + s && cyc <= fin);
            if (which == 0) begin
                start_a = st;
                stall_a = stl;
            end else begin
                start_b = st;
                stall_b = stl;
            end
            tick();
        end
        start_a = 1'b0;
        stall_a = 1'b0;
        start_b = 1'b0;
        stall_b = 1'b0;
    endtask

    initial begin
        xrst    = 1'b1;
        start_a = 1'b0;
        stall_a = 1'b0;
        start_b = 1'b0;
        stall_b = 1'b0;
`ifdef WBANK_SCHED_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_zero_a("rst_a");
        check_eq("rst_b.rd_valid", int'(rd_valid_b), 0);
        check_eq("rst_b.busy", int'(busy_b), 0);
        check_eq("rst_b.finish", int'(finish_b), 0);
        xrst = 1'b0;
        cyc  = 0;

        // Run at 10 with ignored starts at 20 (RUN) and 76 (DONE); rerun accepted at 77.
        run_window(0, 10, Big, 0, 77, 20, 76, 1'b0);
        run_window(0, 77, Big, 0, 146, -1, -1, 1'b0);

        // Three-cycle stall on raddr=5 of pass 2; finish moves to 79.
        cyc = 0;
        run_window(0, 10, 37, 3, 82, -1, -1, 1'b0);

        // Asynchronous reset at cycle 40 aborts the run with no finish.
        cyc = 0;
        run_window(0, 10, Big, 0, 40, -1, -1, 1'b0);
        xrst = 1'b1;
        #1;
        check_zero_a("async_rst");
        tick();
        xrst = 1'b0;
        check_zero_a("post_rst");
        run_window(0, Big, Big, 0, 50, -1, -1, 1'b0);
        run_window(0, 50, Big, 0, 119, -1, -1, 1'b0);

        // Latency 3, single pass; stall held through DRAIN/DONE must not matter.
        cyc = 0;
        run_window(1, 5, Big, 0, 28, -1, -1, 1'b1);

`ifdef WBANK_SCHED_ABORT_EN
        cyc = 0;
        run_window(0, 10, Big, 0, 30, -1, -1, 1'b0);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        for (int i = 0; i < 60; i++) begin
            check_eq("abort.busy", int'(busy_a), 0);
            check_eq("abort.rd_valid", int'(rd_valid_a), 0);
            check_eq("abort.finish", int'(finish_a), 0);
            tick();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
